// File: rtl/tone_sequencer_pkg.sv
// tone_seq_pkg: shared state encoding and note-entry widths for the tone sequencer
package tone_seq_pkg;
  localparam int PERIOD_W = 32;
  localparam int VOL_W = 4;
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
  function automatic int note_w(input int dur_w);
    return PERIOD_W + dur_w + VOL_W;
  endfunction
endpackage

// File: rtl/tone_sequencer_if.sv
// tone_sequencer_if: host write port, playback control and freq_pwm-facing outputs
interface tone_sequencer_if
  import tone_seq_pkg::*;
#(
  parameter int DUR_W = 16,
  parameter int FIFO_DEPTH = 8
);
  logic wr_valid;
  logic wr_ready;
  logic [PERIOD_W-1:0] wr_period;
  logic [DUR_W-1:0] wr_duration;
  logic [VOL_W-1:0] wr_volume;
  logic start;
  logic stop;
  logic [PERIOD_W-1:0] clks_per_period;
  logic new_period;
  logic [VOL_W-1:0] volume;
  logic busy;
  logic note_done;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  modport master (
    output wr_valid, wr_period, wr_duration, wr_volume, start, stop,
    input wr_ready, clks_per_period, new_period, volume, busy, note_done, fifo_count
  );
  modport slave (
    input wr_valid, wr_period, wr_duration, wr_volume, start, stop,
    output wr_ready, clks_per_period, new_period, volume, busy, note_done, fifo_count
  );
endinterface

// File: rtl/tone_sequencer_note_fifo.sv
// note_fifo: single-clock note queue with valid/ready write, pop strobe and occupancy count
module note_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 52
) (
  input  logic clk,
  input  logic reset,
  input  logic wr_valid,
  output logic wr_ready,
  input  logic [W-1:0] wr_data,
  input  logic pop,
  output logic [W-1:0] rd_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push;
  assign wr_ready = count != (AW+1)'(DEPTH);
  assign push = wr_valid && wr_ready;
  assign rd_data = mem[rd_ptr];
  // storage is not reset; only pointers and count define validity
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: plays queued notes into freq_pwm; define TONE_SEQ_GAP_EN for inter-note silence
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DUR_W = 16,
  parameter int TICK_DIV = 100000,
  parameter int GAP_TICKS = 10
) (
  input logic clk,
  input logic reset,
  tone_sequencer_if.slave bus
);
  localparam int NW = note_w(DUR_W);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_TICKS - 1);
`ifdef TONE_SEQ_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  state_t state, state_n;
  logic [NW-1:0] head;
  logic [DUR_W-1:0] head_dur, tick, tick_n, dur, dur_n;
  logic [PW-1:0] presc, presc_n;
  logic [PERIOD_W-1:0] period_n;
  logic [VOL_W-1:0] vol_n;
  logic pop, np_n, done_n, wrap;
  note_fifo #(.DEPTH(FIFO_DEPTH), .W(NW)) fifo (
    .clk(clk),
    .reset(reset),
    .wr_valid(bus.wr_valid),
    .wr_ready(bus.wr_ready),
    .wr_data({bus.wr_period, bus.wr_duration, bus.wr_volume}),
    .pop(pop),
    .rd_data(head),
    .count(bus.fifo_count)
  );
  assign head_dur = head[VOL_W +: DUR_W];
  assign wrap = presc == PW'(TICK_DIV - 1);
  assign bus.busy = state != IDLE;
  // next state and next output values; GAP is only reachable when the gap feature is built in
  always_comb begin
    state_n = state;
    period_n = bus.clks_per_period;
    vol_n = bus.volume;
    np_n = 1'b0;
    done_n = 1'b0;
    pop = 1'b0;
    presc_n = wrap ? '0 : presc + 1'b1;
    tick_n = wrap ? tick + 1'b1 : tick;
    dur_n = dur;
    case (state)
      IDLE: state_n = bus.start && !bus.stop && bus.fifo_count != '0 ? LOAD : IDLE;
      LOAD: begin
        pop = 1'b1;
        state_n = PLAY;
        period_n = head[NW-1 -: PERIOD_W];
        vol_n = head[VOL_W-1:0];
        dur_n = head_dur == '0 ? DUR_W'(1) : head_dur;
        np_n = 1'b1;
        presc_n = '0;
        tick_n = '0;
      end
      PLAY:
        if (wrap && tick == dur - 1'b1) begin
          done_n = 1'b1;
          presc_n = '0;
          tick_n = '0;
          state_n = GAP_EN ? GAP : bus.fifo_count != '0 ? LOAD : IDLE;
          np_n = GAP_EN || bus.fifo_count == '0;
          period_n = np_n ? '0 : bus.clks_per_period;
        end
      default:
        if (wrap && tick == GAP_LAST) state_n = bus.fifo_count != '0 ? LOAD : IDLE;
    endcase
    if (bus.stop && state != IDLE) begin
      state_n = IDLE;
      period_n = '0;
      np_n = 1'b1;
      done_n = 1'b0;
      pop = 1'b0;
    end
  end
  // state, counters and registered outputs
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      presc <= '0;
      tick <= '0;
      dur <= '0;
      bus.clks_per_period <= '0;
      bus.volume <= '0;
      bus.new_period <= 1'b0;
      bus.note_done <= 1'b0;
    end else begin
      state <= state_n;
      presc <= presc_n;
      tick <= tick_n;
      dur <= dur_n;
      bus.clks_per_period <= period_n;
      bus.volume <= vol_n;
      bus.new_period <= np_n;
      bus.note_done <= done_n;
    end
endmodule
